nibble_serial_alu_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ALU_CTRL -- requirements
Module: nibble_serial_alu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  16  operand A.
REQ-006 b  input  16  operand B.
REQ-007 s  input  3  opcode, using the slice encoding: 000 clear, 001 B-A, 010 A-B, 011 A+B, 100 XOR, 101 OR, 110 AND, 111 preset.
REQ-008 slice_a  output  4  current A nibble driven to the external 4-bit ALU slice.
REQ-009 slice_b  output  4  current B nibble driven to the slice.
REQ-010 slice_s  output  3  latched opcode driven to the slice.
REQ-011 slice_cin  output  1  carry into the current nibble.
REQ-012 slice_f  input  4  slice result nibble; combinational from slice_a/b/s/cin.
REQ-013 slice_g  input  1  slice carry-generate, active-high.
REQ-014 slice_p  input  1  slice carry-propagate, active-high.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse when result is valid.
REQ-017 result  output  16  assembled result; held until the next accepted start.
REQ-018 cout  output  1  carry out of nibble 3.
REQ-019 zero  output  1  high when result == 16'h0000; valid with done.

Function
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 IDLE: start=1 SHALL latch a, b and s, clear nidx to 0, load carry with cin0, and go to RUN.
REQ-022 cin0 SHALL be 1 for s=001/010 and 0 for all other opcodes.
REQ-023 RUN: slice_a/slice_b SHALL carry nibble nidx of the latched operands (nidx=0 is bits 3:0), and slice_cin SHALL equal carry.
REQ-024 Each RUN cycle SHALL write slice_f into result[4*nidx+3:4*nidx].
REQ-025 Each RUN cycle SHALL update carry to slice_g | (slice_p & carry).
REQ-026 Each RUN cycle SHALL increment the 2-bit nidx.
REQ-027 RUN SHALL last exactly 4 cycles; when nidx=3, it SHALL go to DONE and latch cout from the updated carry.
REQ-028 DONE SHALL assert done for one cycle, update zero from the full result, and return to IDLE.
REQ-029 Latency: start sampled at edge N; done high during the cycle after edge N+5; back-to-back start is accepted in the cycle after DONE.
REQ-030 start SHALL be ignored while in RUN or DONE, and operand changes SHALL have no effect after latch.
REQ-031 Outside RUN, slice_a/b/cin SHALL be 0 and slice_s SHALL hold its last value.
REQ-032 The nidx wrap 3->0 SHALL coincide only with leaving RUN and SHALL never re-enter nibble 0 within an operation.

Reset
REQ-033 Assertion of rst_n=0 SHALL immediately force IDLE and set busy, done, result, cout, zero, carry, nidx, slice_s and the operand latches to 0.
REQ-034 A reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-035 After rst_n deasserts, the first start SHALL be accepted normally.

Structure
REQ-036 Package alu_pkg SHALL hold the opcode constants, the FSM state enum and NIBBLES=4.
REQ-037 The block SHALL contain one sub-module, gp_carry (carry = g | p&cin); all other logic is inline.

Verification
REQ-038 The bench SHALL model the slice behaviourally, with g/p as true generate/propagate of the operation:
- A+B: F=A+B+cin
- A-B: F=A+~B+cin
- B-A: F=B+~A+cin
REQ-039 Add with carry ripple: s=011, a=0x00FF, b=0x0001 -> result 0x0100, cout=0, zero=0, done exactly 5 cycles after start.
REQ-040 Add with wrap: s=011, a=0xFFFF, b=0x0001 -> result 0x0000, cout=1, zero=1.
REQ-041 Subtract: s=010, a=0x1234, b=0x0234 -> result 0x1000, cout=1; then s=001 with the same operands -> result 0xF000, cout=0.
REQ-042 Busy and logic ops: start pulsed during RUN with different operands is ignored; then s=110, a=0xF0F0, b=0xFF00 -> result 0xF000.
REQ-043 Reset abort: rst_n low in the 3rd RUN cycle -> all outputs 0 immediately, no done; next start s=111 -> result 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and geometry for the nibble-serial ALU controller.
package alu_pkg;

    localparam int NIBBLES  = 4;
    localparam int NIBBLE_W = 4;
    localparam int DATA_W   = NIBBLES * NIBBLE_W;
    localparam int NIDX_W   = $clog2(NIBBLES);

    localparam logic [2:0] OP_CLR    = 3'b000;
    localparam logic [2:0] OP_BMA    = 3'b001;
    localparam logic [2:0] OP_AMB    = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_AND    = 3'b110;
    localparam logic [2:0] OP_PRESET = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        s;
    } op_t;

    // Subtracts are A + ~B + 1, so their carry chain starts at 1.
    function automatic logic cin0(input logic [2:0] op);
        logic c;
        case (op)
            OP_BMA, OP_AMB:                                    c = 1'b1;
            OP_CLR, OP_ADD, OP_XOR, OP_OR, OP_AND, OP_PRESET: c = 1'b0;
            default:                                           c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gp_carry.sv
// Carry lookahead cell: next carry from slice generate/propagate and incoming carry.
module gp_carry (
    input  logic i_g,
    input  logic i_p,
    input  logic i_cin,
    output logic o_cout
);

    assign o_cout = i_g | (i_p & i_cin);

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Drives a 16-bit operation through an external 4-bit ALU slice, one nibble per cycle.
// start accepted only in IDLE; done pulses 5 cycles after the accepting edge; no backpressure.
module nibble_serial_alu_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        s,
    output logic [3:0]        slice_a,
    output logic [3:0]        slice_b,
    output logic [2:0]        slice_s,
    output logic              slice_cin,
    input  logic [3:0]        slice_f,
    input  logic              slice_g,
    input  logic              slice_p,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              zero
);

    localparam logic [NIDX_W-1:0] NIDX_LAST = NIDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                r_op;
    logic [NIDX_W-1:0]  r_nidx;
    logic               r_carry;
    logic [DATA_W-1:0]  r_result;
    logic               r_cout;
    logic               r_done;
    logic               r_zero;

    logic               w_run;
    logic               w_accept;
    logic               w_last;
    logic               w_carry_nxt;
    logic [3:0]         w_bit_base;

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_last     = (r_nidx == NIDX_LAST);
    assign w_bit_base = {r_nidx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:             w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    gp_carry u_gp_carry (
        .i_g    (slice_g),
        .i_p    (slice_p),
        .i_cin  (r_carry),
        .o_cout (w_carry_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_nidx   <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op    <= '{a: a, b: b, s: s};
                r_nidx  <= '0;
                r_carry <= cin0(s);
            end
            if (w_run) begin
                r_result[w_bit_base +: 4] <= slice_f;
                r_carry                   <= w_carry_nxt;
                r_nidx                    <= r_nidx + NIDX_W'(1);
                if (w_last) begin
                    r_cout <= w_carry_nxt;
                end
            end
            // The last nibble lands on the RUN->DONE edge, so zero is taken one cycle later.
            if (r_state == ST_DONE) begin
                r_done <= 1'b1;
                r_zero <= (r_result == '0);
            end
        end
    end

    assign slice_a   = w_run ? r_op.a[w_bit_base +: 4] : 4'h0;
    assign slice_b   = w_run ? r_op.b[w_bit_base +: 4] : 4'h0;
    assign slice_cin = w_run ? r_carry : 1'b0;
    assign slice_s   = r_op.s;

    assign busy   = w_run;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: behavioural 4-bit slice plus a queue of expected results.
module tb_nibble_serial_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic [2:0]  s;
    logic [3:0]  slice_a, slice_b, slice_f;
    logic [2:0]  slice_s;
    logic        slice_cin, slice_g, slice_p;
    logic        busy, done, cout, zero;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_alu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .s         (s),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_s   (slice_s),
        .slice_cin (slice_cin),
        .slice_f   (slice_f),
        .slice_g   (slice_g),
        .slice_p   (slice_p),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
    );

    // External slice: true generate/propagate for the arithmetic ops, none for logic ops.
    logic [3:0] mx, my;
    logic [4:0] mt;
    always_comb begin
        mx      = slice_a;
        my      = slice_b;
        mt      = 5'd0;
        slice_f = 4'h0;
        slice_g = 1'b0;
        slice_p = 1'b0;
        case (slice_s)
            3'b001: begin mx = slice_b; my = ~slice_a; end
            3'b010: begin mx = slice_a; my = ~slice_b; end
            default: ;
        endcase
        mt = {1'b0, mx} + {1'b0, my};
        case (slice_s)
            3'b001, 3'b010, 3'b011: begin
                slice_f = mt[3:0] + {3'b000, slice_cin};
                slice_g = mt[4];
                slice_p = (mt == 5'd15);
            end
            3'b100:  slice_f = slice_a ^ slice_b;
            3'b101:  slice_f = slice_a | slice_b;
            3'b110:  slice_f = slice_a & slice_b;
            3'b111:  slice_f = 4'hF;
            default: slice_f = 4'h0;
        endcase
    end

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic [2:0] ms);
        logic [16:0] w;
        exp_t        e;
        case (ms)
            3'b001:  w = {1'b0, mb} + {1'b0, ~ma} + 17'd1;
            3'b010:  w = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
            3'b011:  w = {1'b0, ma} + {1'b0, mb};
            3'b100:  w = {1'b0, ma ^ mb};
            3'b101:  w = {1'b0, ma | mb};
            3'b110:  w = {1'b0, ma & mb};
            3'b111:  w = {1'b0, 16'hFFFF};
            default: w = 17'd0;
        endcase
        e.res  = w[15:0];
        e.cout = w[16];
        e.zero = (w[15:0] == 16'h0000);
        return e;
    endfunction

    // Entry: #1 after a rising edge with the DUT in IDLE. Exit: #1 after the edge that raised done.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] ts, input bit poke);
        exp_t e;
        bit   found;
        a     = ta;
        b     = tb;
        s     = ts;
        start = 1'b1;
        exp_q.push_back(model(ta, tb, ts));
        @(posedge clk); #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        s     = 3'($urandom_range(0, 7));
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (k < 4) begin
                checks++;
                if (busy !== 1'b1 || slice_a !== ta[4*k +: 4] || slice_b !== tb[4*k +: 4] || slice_s !== ts)
                    $display("FAIL run_nibble%0d: busy=%b a=%h b=%h s=%b required busy=1 a=%h b=%h s=%b",
                             k, busy, slice_a, slice_b, slice_s, 1'b1, ta[4*k +: 4], tb[4*k +: 4], ts);
            end
            if (k == 4) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0)
                    $display("FAIL done_state: busy=%b done=%b required 0 0", busy, done);
            end
            if (poke && k == 1) begin
                start = 1'b1;
                a     = ~ta;
                b     = ~tb;
            end
            if (poke && k == 2) start = 1'b0;
            if (done === 1'b1) begin
                found = 1'b1;
                checks++;
                if (k != 5) begin
                    errors++;
                    $display("FAIL latency: done after %0d cycles required 5", k);
                end
                e = exp_q.pop_front();
                checks++;
                if (result !== e.res || cout !== e.cout || zero !== e.zero) begin
                    errors++;
                    $display("FAIL result op=%b a=%h b=%h: got %h cout=%b zero=%b required %h cout=%b zero=%b",
                             ts, ta, tb, result, cout, zero, e.res, e.cout, e.zero);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!found) begin
            errors++;
            $display("FAIL done_timeout: op=%b no done within 12 cycles required done at 5", ts);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        s     = 3'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, result, cout, zero, slice_a, slice_b, slice_s, slice_cin} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h cout=%b zero=%b slice_s=%b required all 0",
                     busy, done, result, cout, zero, slice_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        do_op(16'h00FF, 16'h0001, 3'b011, 1'b0);
        do_op(16'hFFFF, 16'h0001, 3'b011, 1'b0);
    endtask

    task automatic test_sub;
        do_op(16'h1234, 16'h0234, 3'b010, 1'b0);
        do_op(16'h1234, 16'h0234, 3'b001, 1'b0);
    endtask

    task automatic test_busy_ignore;
        do_op(16'h1111, 16'h2222, 3'b011, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h3333) begin
                errors++;
                $display("FAIL ignored_start: cycle %0d done=%b busy=%b result=%h required 0 0 3333",
                         k, done, busy, result);
            end
        end
        do_op(16'hF0F0, 16'hFF00, 3'b110, 1'b0);
        do_op(16'hA5A5, 16'h0FF0, 3'b100, 1'b0);
        do_op(16'hA500, 16'h005A, 3'b101, 1'b0);
        do_op(16'h1234, 16'h5678, 3'b000, 1'b0);
    endtask

    task automatic test_reset_abort;
        @(posedge clk); #1;
        a     = 16'h1357;
        b     = 16'h2468;
        s     = 3'b011;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || slice_a !== 4'h3) begin
            errors++;
            $display("FAIL abort_setup: busy=%b slice_a=%h required 1 3", busy, slice_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, cout, zero, slice_a, slice_b, slice_s, slice_cin} !== '0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b result=%h cout=%b zero=%b slice_s=%b required all 0",
                     busy, done, result, cout, zero, slice_s);
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: cycle %0d done=%b busy=%b required 0 0", k, done, busy);
            end
        end
        do_op(16'h0000, 16'h0000, 3'b111, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++)
            do_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
